// File: rtl/seq_mul_pkg.sv
// rtl/seq_mul_pkg.sv - shared types and helpers for the shift-and-add multiplier
package seq_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must hold the value W itself, hence W+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_mul_shift_add_if.sv
// rtl/seq_mul_shift_add_if.sv - request/result bundle for the sequential multiplier
interface seq_mul_shift_add_if
    import seq_mul_pkg::*;
#(
    parameter int W = 16
);
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_mul_ctrl.sv
// rtl/seq_mul_ctrl.sv - FSM, iteration counter and termination decision
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter int W          = 16,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic mb_next_zero,
    output logic load,
    output logic step,
    output logic finish,
    output logic busy,
    output logic done
);
    localparam int             CW       = cnt_width(W);
    localparam logic [CW-1:0]  CNT_INIT = CW'(W);
    localparam logic [CW-1:0]  CNT_LAST = CW'(1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                count <= CNT_INIT;
            end else if (step) begin
                count <= count - CNT_LAST;
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        busy       = (state != IDLE);
        done       = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                // count==1 here means this is the last of the W iterations
                if ((count == CNT_LAST) || (EARLY_TERM && mb_next_zero)) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: rtl/seq_mul_shift_add.sv
// rtl/seq_mul_shift_add.sv - sequential shift-and-add multiplier, one multiplier bit per clock
module seq_mul_shift_add
    import seq_mul_pkg::*;
#(
    parameter int W          = 16,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seq_mul_shift_add_if.slave bus
);
    logic [2*W-1:0] acc;
    logic [2*W-1:0] mc;
    logic [W-1:0]   mb;
    logic           neg;
    logic [2*W-1:0] product_q;

    logic           load;
    logic           step;
    logic           finish;
    logic           mb_next_zero;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [2*W-1:0] acc_next;
    logic [2*W-1:0] result;

    // Signed operands are multiplied as magnitudes; the sign is reapplied at the end.
    // The magnitude of -2^(W-1) is 2^(W-1), which still fits in W unsigned bits.
    always_comb begin
        a_mag        = (bus.signed_mode && bus.a[W-1]) ? (~bus.a + 1'b1) : bus.a;
        b_mag        = (bus.signed_mode && bus.b[W-1]) ? (~bus.b + 1'b1) : bus.b;
        acc_next     = mb[0] ? (acc + mc) : acc;
        result       = neg ? (~acc_next + 1'b1) : acc_next;
        mb_next_zero = (mb[W-1:1] == '0);
    end

    seq_mul_ctrl #(
        .W          (W),
        .EARLY_TERM (EARLY_TERM)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .start        (bus.start),
        .mb_next_zero (mb_next_zero),
        .load         (load),
        .step         (step),
        .finish       (finish),
        .busy         (bus.busy),
        .done         (bus.done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            mc        <= '0;
            mb        <= '0;
            neg       <= 1'b0;
            product_q <= '0;
        end else if (load) begin
            acc <= '0;
            mc  <= {{W{1'b0}}, a_mag};
            mb  <= b_mag;
            neg <= bus.signed_mode & (bus.a[W-1] ^ bus.b[W-1]);
        end else if (step) begin
            acc <= acc_next;
            mc  <= mc << 1;
            mb  <= mb >> 1;
            if (finish) begin
                product_q <= result;
            end
        end
    end

    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_mul_shift_add.sv
// tb/tb_seq_mul_shift_add.sv - directed vector bench for seq_mul_shift_add
module tb_seq_mul_shift_add;
    import seq_mul_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_mul_shift_add_if #(.W(16)) if_et ();
    seq_mul_shift_add_if #(.W(16)) if_ft ();

    seq_mul_shift_add #(.W(16), .EARLY_TERM(1'b1)) u_et (.clk(clk), .rst(rst), .bus(if_et.slave));
    seq_mul_shift_add #(.W(16), .EARLY_TERM(1'b0)) u_ft (.clk(clk), .rst(rst), .bus(if_ft.slave));

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        ft;
        logic        sm;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        int          runs;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ft, input logic sm, input logic [15:0] a, input logic [15:0] b);
        if_et.start = !ft;
        if_ft.start = ft;
        if_et.signed_mode = sm;
        if_ft.signed_mode = sm;
        if_et.a = a;  if_ft.a = a;
        if_et.b = b;  if_ft.b = b;
    endtask

    // Called just after the accept edge; returns at the negedge where done is seen.
    task automatic wait_done(input logic ft, output int runs, output logic [31:0] prod, output logic seen);
        runs = 0;
        seen = 1'b0;
        prod = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ft ? if_ft.done : if_et.done) begin
                seen = 1'b1;
                prod = ft ? if_ft.product : if_et.product;
                break;
            end
            if (ft ? if_ft.busy : if_et.busy) runs++;
        end
    endtask

    task automatic do_op(input string name, input logic ft, input logic sm, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exp_prod, input int exp_runs);
        int          runs;
        logic [31:0] prod;
        logic        seen;
        @(negedge clk);
        drive(ft, sm, a, b);
        @(posedge clk);
        #1;
        if_et.start = 1'b0;
        if_ft.start = 1'b0;
        wait_done(ft, runs, prod, seen);
        check({name, "_done_seen"}, 64'(seen), 64'd1);
        check({name, "_product"}, 64'(prod), 64'(exp_prod));
        check({name, "_runs"}, 64'(runs), 64'(exp_runs));
        check({name, "_busy_in_done"}, 64'(ft ? if_ft.busy : if_et.busy), 64'd1);
        @(negedge clk);
        check({name, "_done_one_cycle"}, 64'(ft ? if_ft.done : if_et.done), 64'd0);
        check({name, "_idle"}, 64'(ft ? if_ft.busy : if_et.busy), 64'd0);
    endtask

    initial begin
        int          runs;
        logic [31:0] prod;
        logic        seen;
        logic        done_seen;

        vecs[0] = '{1'b0, 1'b0, 16'd3,    16'd5,    32'h0000000F, 3};
        vecs[1] = '{1'b0, 1'b0, 16'h04D2, 16'h0000, 32'h00000000, 1};
        vecs[2] = '{1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16};
        vecs[3] = '{1'b0, 1'b1, 16'hFFFD, 16'd7,    32'hFFFFFFEB, 3};
        vecs[4] = '{1'b0, 1'b1, 16'h8000, 16'h8000, 32'h40000000, 16};
        vecs[5] = '{1'b1, 1'b0, 16'd3,    16'd1,    32'h00000003, 16};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h00F0, 32'h00000000, 8};
        vecs[7] = '{1'b0, 1'b1, 16'd7,    16'hFFFE, 32'hFFFFFFF2, 2};
        vecs[8] = '{1'b0, 1'b1, 16'h8000, 16'd1,    32'hFFFF8000, 1};
        vecs[9] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001, 16};

        drive(1'b0, 1'b0, 16'd0, 16'd0);
        if_et.start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'({if_et.busy, if_ft.busy}), 64'd0);
        check("reset_done", 64'({if_et.done, if_ft.done}), 64'd0);
        check("reset_product_et", 64'(if_et.product), 64'd0);
        check("reset_product_ft", 64'(if_ft.product), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].ft, vecs[i].sm, vecs[i].a, vecs[i].b,
                  vecs[i].prod, vecs[i].runs);
        end

        // start held high through an operation with changing operands
        @(negedge clk);
        drive(1'b0, 1'b0, 16'd3, 16'd5);
        @(posedge clk);
        runs = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (if_et.done) begin
                seen = 1'b1;
                break;
            end
            if (if_et.busy) runs++;
            if_et.a = 16'(100 + i);
            if_et.b = 16'(200 + i);
        end
        check("ignore_done_seen", 64'(seen), 64'd1);
        check("ignore_product", 64'(if_et.product), 64'h0F);
        check("ignore_runs", 64'(runs), 64'd3);
        if_et.a = 16'd6;
        if_et.b = 16'd7;
        @(negedge clk);
        check("b2b_idle_after_done", 64'(if_et.busy), 64'd0);
        @(posedge clk);
        #1;
        if_et.start = 1'b0;
        wait_done(1'b0, runs, prod, seen);
        check("b2b_done_seen", 64'(seen), 64'd1);
        check("b2b_product", 64'(prod), 64'd42);
        check("b2b_runs", 64'(runs), 64'd3);

        // reset in the middle of RUN
        @(negedge clk);
        drive(1'b0, 1'b0, 16'd5, 16'h00FF);
        @(posedge clk);
        #1;
        if_et.start = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_busy_before_rst", 64'(if_et.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrun_rst_busy", 64'(if_et.busy), 64'd0);
        check("midrun_rst_done", 64'(if_et.done), 64'd0);
        check("midrun_rst_product", 64'(if_et.product), 64'd0);
        rst = 1'b0;
        done_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if_et.done || if_et.busy) done_seen = 1'b1;
        end
        check("midrun_no_done", 64'(done_seen), 64'd0);
        do_op("after_rst", 1'b0, 1'b0, 16'd2, 16'd9, 32'd18, 4);

        // reset and start on the same edge
        @(negedge clk);
        drive(1'b0, 1'b0, 16'd7, 16'd7);
        rst = 1'b1;
        @(negedge clk);
        check("rst_start_busy", 64'(if_et.busy), 64'd0);
        check("rst_start_product", 64'(if_et.product), 64'd0);
        rst = 1'b0;
        if_et.start = 1'b0;
        @(negedge clk);
        check("rst_start_still_idle", 64'(if_et.busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_mul_shift_add.md
Name: seq_mul_shift_add

Overview:
- Parametrised sequential multiplier: shift-and-add, one multiplier bit per clock.
- Integrated controller with start/busy/done handshake.
- Supports an unsigned or signed (two's-complement) mode selected per operation.
- Optional early termination once the remaining multiplier bits are zero.
- Replaces repeated-addition multiply units in compute datapaths; product is held for the consumer until the next operation starts.

Parameters:
- W, 16, operand width in bits; W >= 2; product is 2W bits.
- EARLY_TERM, 1, 1 = finish as soon as the remaining multiplier bits are zero; 0 = always run exactly W iterations.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- signed_mode  in  1  sampled with start; 1 = a and b are two's-complement.
- a  in  W  multiplicand, sampled on the accepting edge.
- b  in  W  multiplier, sampled on the accepting edge.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse, high in the DONE state.
- product  out  2W  result; valid from done high until the next accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high and overrides everything, including an operation in progress.
- Reset values: state = IDLE, busy = 0, done = 0, product = 0, all internal registers = 0.
- States:
  - IDLE: if start = 1 at a rising edge, capture the operands and go to RUN. If signed_mode = 1, capture |a| and |b| zero-extended and record neg = a[W-1] ^ b[W-1]; otherwise neg = 0. Clear the accumulator to 0 and load iteration count = W. product keeps its old value until DONE.
  - RUN, each cycle:
    - if mb[0] = 1, acc <= acc + mc, where mc is the 2W-bit shifted multiplicand;
    - mc <= mc << 1; mb <= mb >> 1; count <= count - 1;
    - leave for DONE when count reaches 0, or when EARLY_TERM = 1 and the next mb == 0.
    - On the exit edge, product <= neg ? -(final acc) : final acc, computed mod 2^(2W).
  - DONE: done = 1 for exactly one cycle, then return to IDLE unconditionally.
- Latency:
  - EARLY_TERM = 1: n = max(1, index of the MSB of |b| + 1) RUN cycles.
  - EARLY_TERM = 0: n = W RUN cycles.
  - With start accepted at edge k, RUN covers cycles k+1..k+n, done is high in cycle k+n+1, and the next start can be accepted at the edge ending that cycle + 1 (IDLE).
- Arithmetic:
  - The accumulator is 2W bits; the unsigned product never overflows.
  - Signed mode: magnitudes fit in W bits unsigned, including -2^(W-1). The result is exact; (-2^(W-1))^2 = 2^(2W-2) fits in 2W bits.
- Boundaries:
  - start while busy (RUN or DONE): ignored. Operands are not re-sampled and no error is flagged.
  - rst during RUN or DONE: on the next edge go to IDLE with product = 0 and done = 0; no done pulse for the aborted operation.
  - rst and start on the same edge: reset wins.
  - b = 0 (or |b| = 0): one RUN cycle, product = 0.
  - a = 0: full iteration count per the latency rule, product = 0.
- signed_mode, a and b are don't-care outside the accepting edge.

Decomposition:
- Package seq_mul_pkg holds:
  - the state encoding type (IDLE, RUN, DONE);
  - the width helper for the counter, clog2(W+1);
  - the enumerated constants.
- Natural split into two sub-modules:
  - seq_mul_ctrl: FSM, counter, done/busy and early-termination decision, driven by a zero flag from the datapath.
  - The parent: registers, adder and shifters, in the same datapath/controller style as the team's other arithmetic blocks.

Test Plan:
- W=16, unsigned, a=3, b=5 -> 3 RUN cycles, done 4 cycles after the accept edge, product = 0x0000000F.
- Unsigned a=0x04D2, b=0 -> 1 RUN cycle, product = 0; then a=0xFFFF, b=0xFFFF -> 16 RUN cycles, product = 0xFFFE0001.
- Signed a=-3 (0xFFFD), b=7 -> product = 0xFFFFFFEB (-21), 3 RUN cycles; signed a=0x8000, b=0x8000 -> product = 0x40000000.
- EARLY_TERM=0, unsigned a=3, b=1 -> exactly 16 RUN cycles, product = 3; busy high for 17 cycles after accept.
- start pulsed every cycle during an operation with different a/b -> ignored, first result unchanged; a back-to-back start the cycle after done falls is accepted.
- rst asserted mid-RUN (a=5, b=0x00FF) -> next cycle IDLE, busy = 0, done never pulses, product = 0; a new operation 2*9 completes with product = 18.
